// File: rtl/encrypt_mul_scheduler.sv
// Baby Kyber encryption product scheduler: runs the six polynomial products of
// u = A^T*r + e1 and v = t^T*r + e2 + scaled message through one shared multiplier.
module encrypt_mul_scheduler #(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int K     = 2,
   parameter int Q     = 17,
   parameter int QHALF = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [K*K*N*W-1:0]   a_mat,
   input  logic [K*N*W-1:0]     t_vec,
   input  logic [K*N*W-1:0]     r_vec,
   input  logic [K*N*W-1:0]     e1_vec,
   input  logic [N*W-1:0]       e2_poly,
   input  logic [N-1:0]         m_bits,
   output logic                 mul_req,
   output logic [N*W-1:0]       mul_a,
   output logic [N*W-1:0]       mul_b,
   input  logic                 mul_ack,
   input  logic [N*W-1:0]       mul_result,
   output logic                 busy,
   output logic                 done,
   output logic [K*N*W-1:0]     u_out,
   output logic [N*W-1:0]       v_out
);

   localparam int PW = N*W;
   localparam int SW = W+2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MUL   = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic signed [SW-1:0] QH    = SW'(QHALF);
   localparam logic signed [SW-1:0] QZERO = '0;

   logic [1:0]           state;
   logic [2:0]           idx;
   logic [K*K*PW-1:0]    a_reg;
   logic [K*PW-1:0]      t_reg;
   logic [K*PW-1:0]      r_reg;
   logic [K*PW-1:0]      e1_reg;
   logic [PW-1:0]        e2_reg;
   logic [N-1:0]         m_reg;
   logic [PW-1:0]        acc_u0;
   logic [PW-1:0]        acc_u1;
   logic [PW-1:0]        acc_v;
   logic [PW-1:0]        acc_sel;
   logic [PW-1:0]        acc_sum;
   logic [PW-1:0]        u0_next;
   logic [PW-1:0]        u1_next;
   logic [PW-1:0]        v_next;

   // Non-negative residue; the remainder of a negative dividend is negative.
   function automatic logic [W-1:0] mod_q(input logic signed [SW-1:0] x);
      logic signed [SW-1:0] q_s;
      logic signed [SW-1:0] r;
      q_s = SW'(Q);
      r = x % q_s;
      if (r[SW-1])
         r = r + q_s;
      return r[W-1:0];
   endfunction

   function automatic logic signed [SW-1:0] sext(input logic [W-1:0] c);
      return {{2{c[W-1]}}, c};
   endfunction

   assign mul_req = (state == S_MUL);
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);

   // Fixed issue order: u0 terms, u1 terms, then v terms.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (state == S_MUL) begin
         case (idx)
            3'd0: begin mul_a = a_reg[(0*K+0)*PW +: PW]; mul_b = r_reg[0  +: PW]; end
            3'd1: begin mul_a = a_reg[(1*K+0)*PW +: PW]; mul_b = r_reg[PW +: PW]; end
            3'd2: begin mul_a = a_reg[(0*K+1)*PW +: PW]; mul_b = r_reg[0  +: PW]; end
            3'd3: begin mul_a = a_reg[(1*K+1)*PW +: PW]; mul_b = r_reg[PW +: PW]; end
            3'd4: begin mul_a = t_reg[0  +: PW];         mul_b = r_reg[0  +: PW]; end
            3'd5: begin mul_a = t_reg[PW +: PW];         mul_b = r_reg[PW +: PW]; end
            default: ;
         endcase
      end
   end

   always_comb begin
      acc_sum = '0;
      u0_next = '0;
      u1_next = '0;
      v_next  = '0;
      if (idx < 3'd2)
         acc_sel = acc_u0;
      else if (idx < 3'd4)
         acc_sel = acc_u1;
      else
         acc_sel = acc_v;
      for (int c = 0; c < N; c++) begin
         acc_sum[c*W +: W] = mod_q(sext(acc_sel[c*W +: W]) + sext(mul_result[c*W +: W]));
         u0_next[c*W +: W] = mod_q(sext(acc_u0[c*W +: W]) + sext(e1_reg[c*W +: W]));
         u1_next[c*W +: W] = mod_q(sext(acc_u1[c*W +: W]) + sext(e1_reg[PW + c*W +: W]));
         v_next[c*W +: W]  = mod_q(sext(acc_v[c*W +: W]) + sext(e2_reg[c*W +: W])
                                   + (m_reg[c] ? QH : QZERO));
      end
   end

   // Operand snapshot needs no reset; it is only read after an accepted start.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         a_reg  <= a_mat;
         t_reg  <= t_vec;
         r_reg  <= r_vec;
         e1_reg <= e1_vec;
         e2_reg <= e2_poly;
         m_reg  <= m_bits;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= '0;
         acc_u0 <= '0;
         acc_u1 <= '0;
         acc_v  <= '0;
         u_out  <= '0;
         v_out  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_MUL;
                  idx    <= '0;
                  acc_u0 <= '0;
                  acc_u1 <= '0;
                  acc_v  <= '0;
               end
            end
            S_MUL: begin
               if (mul_ack) begin
                  if (idx < 3'd2)
                     acc_u0 <= acc_sum;
                  else if (idx < 3'd4)
                     acc_u1 <= acc_sum;
                  else
                     acc_v <= acc_sum;
                  if (idx == 3'd5)
                     state <= S_FINAL;
                  else
                     idx <= idx + 3'd1;
               end
            end
            S_FINAL: begin
               u_out <= {u1_next, u0_next};
               v_out <= v_next;
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encrypt_mul_scheduler.sv
// Directed bench for encrypt_mul_scheduler with a negacyclic multiplier responder
// that can insert ack gaps and checks operand order and stability.
module tb_encrypt_mul_scheduler;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int K  = 2;
   localparam int Q  = 17;
   localparam int PW = N*W;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [K*K*PW-1:0]    a_mat = '0;
   logic [K*PW-1:0]      t_vec = '0;
   logic [K*PW-1:0]      r_vec = '0;
   logic [K*PW-1:0]      e1_vec = '0;
   logic [PW-1:0]        e2_poly = '0;
   logic [N-1:0]         m_bits = '0;
   logic                 mul_req;
   logic [PW-1:0]        mul_a;
   logic [PW-1:0]        mul_b;
   logic                 mul_ack = 1'b0;
   logic [PW-1:0]        mul_result = '0;
   logic                 busy;
   logic                 done;
   logic [K*PW-1:0]      u_out;
   logic [PW-1:0]        v_out;

   always #5 clk = ~clk;

   encrypt_mul_scheduler #(.W(W), .N(N), .K(K), .Q(Q), .QHALF(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_mat(a_mat), .t_vec(t_vec),
      .r_vec(r_vec), .e1_vec(e1_vec), .e2_poly(e2_poly), .m_bits(m_bits),
      .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack),
      .mul_result(mul_result), .busy(busy), .done(done), .u_out(u_out), .v_out(v_out)
   );

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [K*PW-1:0] got,
                              input logic [K*PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] poly(input int c0, input int c1, input int c2, input int c3);
      return {c3, c2, c1, c0};
   endfunction

   // Reference product in Z_Q[x]/(x^N+1).
   function automatic logic [PW-1:0] polymul(input logic [PW-1:0] a, input logic [PW-1:0] b);
      int acc [N];
      int ai, bj, v;
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) acc[i] = 0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            ai = $signed(a[i*W +: W]);
            bj = $signed(b[j*W +: W]);
            if (i + j < N) acc[i+j] += ai * bj;
            else           acc[i+j-N] -= ai * bj;
         end
      end
      for (int i = 0; i < N; i++) begin
         v = acc[i] % Q;
         if (v < 0) v += Q;
         p[i*W +: W] = v;
      end
      return p;
   endfunction

   // Operands the bench expects for the k-th product of the current operation.
   logic [K*K*PW-1:0] cap_a;
   logic [K*PW-1:0]   cap_t;
   logic [K*PW-1:0]   cap_r;

   function automatic logic [PW-1:0] expA(input int k);
      if (k < 4) return cap_a[((k % 2)*K + k/2)*PW +: PW];
      return cap_t[(k-4)*PW +: PW];
   endfunction

   function automatic logic [PW-1:0] expB(input int k);
      return cap_r[(k % 2)*PW +: PW];
   endfunction

   int ack_count = 0;
   int req_cycles = 0;
   int done_count = 0;
   int ack_base = 0;
   int gap_left = 0;
   bit gap_mode = 1'b0;
   bit idle_spam = 1'b0;
   bit prev_stall = 1'b0;
   logic [PW-1:0] prev_a = '0;
   logic [PW-1:0] prev_b = '0;

   always @(negedge clk) begin
      if (mul_req) req_cycles++;
      if (done) done_count++;
      if (prev_stall && mul_req) begin
         checkOutput("stall_a", mul_a, prev_a);
         checkOutput("stall_b", mul_b, prev_b);
      end
      prev_a = mul_a;
      prev_b = mul_b;
      if (idle_spam) begin
         mul_ack = 1'b1;
         mul_result = poly(5, 6, 7, 8);
         prev_stall = 1'b0;
      end else if (mul_req) begin
         if (gap_left > 0) begin
            gap_left--;
            mul_ack = 1'b0;
            prev_stall = 1'b1;
         end else begin
            checkOutput("op_a", mul_a, expA(ack_count - ack_base));
            checkOutput("op_b", mul_b, expB(ack_count - ack_base));
            mul_ack = 1'b1;
            mul_result = polymul(mul_a, mul_b);
            ack_count++;
            prev_stall = 1'b0;
            gap_left = gap_mode ? $urandom_range(0, 3) : 0;
         end
      end else begin
         mul_ack = 1'b0;
         mul_result = '0;
         prev_stall = 1'b0;
         gap_left = gap_mode ? 1 : 0;
      end
   end

   int ack0, req0, done0;

   task automatic setBasic();
      a_mat   = {{(3*PW){1'b0}}, poly(1, 2, 3, 4)};
      t_vec   = {poly(0, 0, 0, 0), poly(16, 16, 16, 16)};
      r_vec   = {poly(0, 0, 0, 0), poly(1, 0, 0, 0)};
      e1_vec  = {poly(0, 0, 0, 0), poly(-1, 0, 1, 0)};
      e2_poly = poly(1, 1, 1, 1);
      m_bits  = 4'b0101;
   endtask

   task automatic snapshot();
      cap_a = a_mat;
      cap_t = t_vec;
      cap_r = r_vec;
      ack_base = ack_count;
      ack0 = ack_count;
      req0 = req_cycles;
      done0 = done_count;
   endtask

   // Pulses start, optionally re-pulses it with new operands at cycle busy_poke,
   // and returns the number of cycles from the accept edge to the done cycle.
   task automatic applyStimulus(input int busy_poke, output int lat);
      snapshot();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      lat = 1;
      while (!done && lat < 300) begin
         if (lat == busy_poke) begin
            start   = 1'b1;
            a_mat   = ~a_mat;
            t_vec   = ~t_vec;
            r_vec   = ~r_vec;
            e1_vec  = poly(2, 2, 2, 2);
            e2_poly = poly(3, 3, 3, 3);
            m_bits  = ~m_bits;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   int lat;

   initial begin
      idle_spam = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_req", mul_req, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_u", u_out, 0);
      checkOutput("rst_v", v_out, 0);
      checkOutput("rst_ops", {mul_a, mul_b}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_req", mul_req, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_u", u_out, 0);
      idle_spam = 1'b0;
      @(negedge clk);

      $display("[TB] basic vector");
      setBasic();
      applyStimulus(0, lat);
      checkOutput("basic_u", u_out, {poly(0, 0, 0, 0), poly(0, 2, 4, 4)});
      checkOutput("basic_v", v_out, poly(9, 0, 9, 0));
      checkOutput("basic_latency", lat, 8);
      checkOutput("basic_acks", ack_count - ack0, 6);
      checkOutput("basic_req_cycles", req_cycles - req0, 6);
      checkOutput("basic_dones", done_count - done0, 1);
      checkOutput("basic_idle_after", busy, 0);

      $display("[TB] backpressure");
      gap_mode = 1'b1;
      setBasic();
      applyStimulus(0, lat);
      gap_mode = 1'b0;
      checkOutput("bp_u", u_out, {poly(0, 0, 0, 0), poly(0, 2, 4, 4)});
      checkOutput("bp_v", v_out, poly(9, 0, 9, 0));
      checkOutput("bp_acks", ack_count - ack0, 6);
      checkOutput("bp_dones", done_count - done0, 1);
      checkOutput("bp_latency_grew", lat > 8, 1);

      $display("[TB] negative wrap");
      a_mat   = '0;
      t_vec   = '0;
      r_vec   = '0;
      e1_vec  = {poly(-1, -1, -1, -1), poly(-1, -1, -1, -1)};
      e2_poly = poly(-1, -1, -1, -1);
      m_bits  = 4'b0000;
      applyStimulus(0, lat);
      checkOutput("neg_u", u_out, {poly(16, 16, 16, 16), poly(16, 16, 16, 16)});
      checkOutput("neg_v", v_out, poly(16, 16, 16, 16));
      checkOutput("neg_latency", lat, 8);

      $display("[TB] start while busy");
      setBasic();
      applyStimulus(4, lat);
      checkOutput("busy_u", u_out, {poly(0, 0, 0, 0), poly(0, 2, 4, 4)});
      checkOutput("busy_v", v_out, poly(9, 0, 9, 0));
      checkOutput("busy_latency", lat, 8);
      checkOutput("busy_dones", done_count - done0, 1);
      checkOutput("busy_acks", ack_count - ack0, 6);

      $display("[TB] reset mid-operation");
      setBasic();
      snapshot();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_req", mul_req, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_u", u_out, 0);
      checkOutput("midrst_v", v_out, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(0, lat);
      checkOutput("after_rst_u", u_out, {poly(0, 0, 0, 0), poly(0, 2, 4, 4)});
      checkOutput("after_rst_v", v_out, poly(9, 0, 9, 0));
      checkOutput("after_rst_latency", lat, 8);
      checkOutput("after_rst_acks", ack_count - ack0, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
